leds_pwm_fader: RTL
===================

# leds_pwm_fader

Downstream LED driver fed by the 32-bit `leds_o` register word of the Wishbone LED CSR block. Interprets the word as eight 4-bit brightness nibbles and drives eight physical LED pins with a 15-step PWM. Optionally ramps each channel one brightness step at a time toward its target. Brightness changes take effect only at PWM period boundaries, so pins never glitch mid-period.

## Interface

Parameters:
- `G_PRESCALE`, default 100: clocks per PWM step. Legal values ≥ 1; value 1 means one step per clock.
- `G_FADE_DIV`, default 1: PWM periods per fade step. Value 0 disables fading, so the level is loaded directly from the target.

Ports:
- `clk_i`  in  1: system clock.
- `rst_n_i`  in  1: reset. One clock; reset is synchronous and active-low.
- `leds_i`  in  32: target brightness word. Nibble k is `leds_i[4k+3:4k]` and drives channel k.
- `leds_o`  out  8: LED pin drive, active high, registered.
- `pwm_period_o`  out  1: single-cycle pulse marking the first cycle of each PWM period, registered.

## Operation

- Prescaler
  - `presc` counts 0..G_PRESCALE-1 and wraps.
  - `tick` = (`presc` == G_PRESCALE-1).
- PWM step counter
  - `pwm_cnt` (4 bits) counts 0..14 and advances on `tick`.
  - It wraps 14→0, so there are 15 steps per period.
- Period boundary
  - `bnd` = `tick` && `pwm_cnt` == 14.
  - At the `bnd` clock edge, `pwm_cnt` returns to 0 and level updates occur.
- Per-channel level `lvl[k]` (4 bits), updated only on `bnd`:
  - G_FADE_DIV = 0: `lvl[k]` ← nibble k of `leds_i`.
  - G_FADE_DIV ≥ 1: `fdiv` counts boundaries 0..G_FADE_DIV-1. When `fdiv` == G_FADE_DIV-1, `fdiv` wraps and each channel takes one fade step:
    - `lvl[k]` += 1 if `lvl[k]` < nibble k.
    - `lvl[k]` -= 1 if `lvl[k]` > nibble k.
    - `lvl[k]` is unchanged if equal.
  - Target is sampled at the step edge only. Changes to `leds_i` between steps are ignored.
  - Arithmetic is unsigned 4-bit and never wraps: the level saturates at the target.
- Output
  - `leds_o[k]` ← (`pwm_cnt` < `lvl[k]`), registered.
  - Level 0 is always off. Level 15 is always on. Level n is on for n of every 15 steps.
- `pwm_period_o` ← `bnd`. It is high in the cycle in which `pwm_cnt` = 0 and the new `lvl` values are visible.
- Reset (`rst_n_i` low at a clock edge, including mid-period): `presc`, `pwm_cnt`, `fdiv` and all `lvl` go to 0. `leds_o` = 0x00 and `pwm_period_o` = 0 from the next cycle. Reset has priority over every other update.

## Timing

- Period length is 15·G_PRESCALE clocks.
- After reset release, the first `bnd` edge is the (15·G_PRESCALE)th rising edge. `pwm_period_o` is high in the cycle after that edge.
- Pin latency: `leds_o` reflects `pwm_cnt`/`lvl` of the previous cycle (1 clock). A new level is therefore first visible on the pin one cycle after `pwm_period_o`.
- Latency from `leds_i` change to level update:
  - G_FADE_DIV = 0: at most one period plus one clock.
  - Fading: |Δ| · G_FADE_DIV periods to reach the target.
- Simultaneous events: a `leds_i` change on the `bnd` edge is sampled, because the value present at that edge wins.
- Counter widths: `presc` uses $clog2(G_PRESCALE) bits, with a minimum of 1. `fdiv` uses $clog2(G_FADE_DIV) bits, with a minimum of 1.

## Structure

- Shared package `leds_pkg` holds:
  - `C_N_LEDS` = 8
  - `C_DUTY_W` = 4
  - `C_PWM_LAST` = 14
  - typedef `duty_t` (logic [3:0])
- Sub-module `leds_pwm_channel`, instantiated C_N_LEDS times:
  - Inputs: `bnd`, `fade_step`, target nibble, `pwm_cnt`.
  - Contents: `lvl` register, fade comparator, output flop.
- Top level contains the prescaler, `pwm_cnt`, `fdiv` and the `pwm_period_o` flop.

## Test plan

All scenarios use G_PRESCALE = 2 (period = 30 clocks).

1. Reset hold, G_FADE_DIV = 0, `leds_i` = 0xFFFF_FFFF, `rst_n_i` low 5 cycles → `leds_o` = 0x00 throughout. After release, the first `pwm_period_o` pulse appears on the 31st cycle, and `leds_o` = 0xFF from the following cycle onward.
2. G_FADE_DIV = 0, `leds_i` = 0x0000_00F5, steady state → per 30-clock period:
   - `leds_o[0]` high exactly 10 contiguous clocks, starting one cycle after `pwm_period_o`.
   - `leds_o[1]` high continuously.
   - `leds_o[7:2]` = 0.
3. G_FADE_DIV = 0, `leds_i` changed 0x3→0xA at period cycle 12 → current period keeps duty 3 (6 clocks high). The next period shows duty 10 (20 clocks high).
4. G_FADE_DIV = 1, nibble 0 stepped 0→F → `lvl[0]` rises 1 per period and reaches 15 after 15 `pwm_period_o` pulses. Then `leds_i` = 0x3 → `lvl[0]` falls to 3 after 12 more pulses and holds, with no overshoot.
5. G_FADE_DIV = 2, nibble 2 = 0x4 from reset → `lvl[2]` increments on every 2nd boundary and reaches 4 after 8 boundaries.
6. Reset pulse (1 cycle) mid-period while fading at `lvl[0]` = 7 → next cycle `leds_o` = 0x00. The fade restarts from 0, and the next `pwm_period_o` comes 30 clocks after release.

Source files
------------

// File: rtl/leds_pkg.sv
// leds_pkg
//    Shared constants and types for the LED PWM fader.
//    C_N_LEDS   : number of LED channels
//    C_DUTY_W   : width of one brightness nibble / PWM step counter
//    C_PWM_LAST : last PWM step index (15 steps per period)
//    duty_t     : brightness level / step counter type
package leds_pkg;
   localparam int          C_N_LEDS   = 8;
   localparam int          C_DUTY_W   = 4;
   localparam logic [3:0]  C_PWM_LAST = 4'd14;

   typedef logic [C_DUTY_W-1:0] duty_t;
endpackage

// File: rtl/leds_pwm_fader_if.sv
// leds_pwm_fader_if
//    Bundles the fader's data signals.
//    leds_i       : 32-bit target word, nibble k -> channel k
//    leds_o       : LED pin drive, active high
//    pwm_period_o : one-clock pulse on the first cycle of each PWM period
//    master : drives the target word, observes pins (register block / bench)
//    slave  : the fader
interface leds_pwm_fader_if;
   import leds_pkg::*;

   logic [C_N_LEDS*C_DUTY_W-1:0] leds_i;
   logic [C_N_LEDS-1:0]          leds_o;
   logic                         pwm_period_o;

   modport master (output leds_i, input leds_o, input pwm_period_o);
   modport slave  (input leds_i, output leds_o, output pwm_period_o);
endinterface

// File: rtl/leds_pwm_channel.sv
// leds_pwm_channel
//    One LED channel: brightness level register, fade comparator and
//    registered pin output.
//    clk_i, rst_n_i : clock, synchronous active-low reset
//    bnd_i          : PWM period boundary strobe
//    fade_step_i    : boundary on which a fade step is taken
//    target_i       : target brightness nibble
//    pwm_cnt_i      : current PWM step 0..14
//    led_o          : registered pin drive
module leds_pwm_channel
   import leds_pkg::*;
#(
   parameter bit G_DIRECT = 1'b0   // 1: load target on every boundary, no fading
) (
   input  logic  clk_i,
   input  logic  rst_n_i,
   input  logic  bnd_i,
   input  logic  fade_step_i,
   input  duty_t target_i,
   input  duty_t pwm_cnt_i,
   output logic  led_o
);

   duty_t lvl_q, lvl_d;
   logic  led_q;

   // Stepping by exactly one toward the target means the level lands on
   // the target and stops there: no wrap, no overshoot.
   always_comb begin
      lvl_d = lvl_q;
      if (G_DIRECT) begin
         if (bnd_i) lvl_d = target_i;
      end else if (fade_step_i) begin
         if (lvl_q < target_i)      lvl_d = lvl_q + duty_t'(1);
         else if (lvl_q > target_i) lvl_d = lvl_q - duty_t'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         lvl_q <= '0;
         led_q <= 1'b0;
      end else begin
         lvl_q <= lvl_d;
         // pwm_cnt never exceeds 14, so level 15 keeps the pin on all period.
         led_q <= (pwm_cnt_i < lvl_q);
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/leds_pwm_fader.sv
// leds_pwm_fader
//    Eight-channel 15-step LED PWM driver with optional per-channel fading.
//    Brightness changes are applied only at period boundaries.
//    G_PRESCALE : clocks per PWM step (>= 1)
//    G_FADE_DIV : PWM periods per fade step; 0 loads the target directly
//    clk_i      : system clock
//    rst_n_i    : synchronous active-low reset
//    bus        : slave side of leds_pwm_fader_if (leds_i, leds_o, pwm_period_o)
module leds_pwm_fader
   import leds_pkg::*;
#(
   parameter int G_PRESCALE = 100,
   parameter int G_FADE_DIV = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   leds_pwm_fader_if.slave        bus
);

   localparam int PW = (G_PRESCALE > 1) ? $clog2(G_PRESCALE) : 1;
   localparam int FW = (G_FADE_DIV > 1) ? $clog2(G_FADE_DIV) : 1;
   localparam logic [PW-1:0] C_PRESC_LAST = PW'(G_PRESCALE - 1);
   localparam logic [FW-1:0] C_FDIV_LAST  = FW'((G_FADE_DIV > 0) ? G_FADE_DIV - 1 : 0);
   localparam bit            C_DIRECT     = (G_FADE_DIV == 0);

   logic [PW-1:0] presc_q, presc_d;
   duty_t         pwm_cnt_q, pwm_cnt_d;
   logic [FW-1:0] fdiv_q, fdiv_d;
   logic          pwm_period_q;
   logic          tick, bnd, fade_step;
   logic [C_N_LEDS-1:0] led_w;

   assign tick      = (presc_q == C_PRESC_LAST);
   assign bnd       = tick && (pwm_cnt_q == C_PWM_LAST);
   assign fade_step = !C_DIRECT && bnd && (fdiv_q == C_FDIV_LAST);

   always_comb begin
      presc_d   = tick ? '0 : presc_q + PW'(1);
      pwm_cnt_d = pwm_cnt_q;
      fdiv_d    = fdiv_q;
      if (tick) pwm_cnt_d = bnd ? '0 : pwm_cnt_q + duty_t'(1);
      // fdiv counts boundaries; it stays at 0 when fading is disabled.
      if (!C_DIRECT && bnd) fdiv_d = (fdiv_q == C_FDIV_LAST) ? '0 : fdiv_q + FW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         presc_q      <= '0;
         pwm_cnt_q    <= '0;
         fdiv_q       <= '0;
         pwm_period_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         pwm_cnt_q    <= pwm_cnt_d;
         fdiv_q       <= fdiv_d;
         pwm_period_q <= bnd;
      end
   end

   for (genvar k = 0; k < C_N_LEDS; k++) begin : g_ch
      leds_pwm_channel #(.G_DIRECT(C_DIRECT)) u_ch (
         .clk_i       (clk_i),
         .rst_n_i     (rst_n_i),
         .bnd_i       (bnd),
         .fade_step_i (fade_step),
         .target_i    (bus.leds_i[k*C_DUTY_W +: C_DUTY_W]),
         .pwm_cnt_i   (pwm_cnt_q),
         .led_o       (led_w[k])
      );
   end

   assign bus.leds_o       = led_w;
   assign bus.pwm_period_o = pwm_period_q;

endmodule
